vga_sync_gen: RTL
=================

// Module: vga_sync_gen
// PURPOSE
//   VGA raster timing generator clocked by the divided 25 MHz pixel clock.
//   Produces hsync/vsync, a display-enable qualifier, current pixel coordinates
//   and a start-of-frame strobe for the downstream pixel/colour stage.
//   Defaults give 640x480 @ 60 Hz (800 x 525 total raster).
// PARAMETERS
//   H_ACTIVE   640  visible pixels per line
//   H_FRONT    16   horizontal front porch (pixels)
//   H_SYNC     96   hsync pulse width (pixels)
//   H_BACK     48   horizontal back porch (pixels)
//   V_ACTIVE   480  visible lines per frame
//   V_FRONT    10   vertical front porch (lines)
//   V_SYNC     2    vsync pulse width (lines)
//   V_BACK     33   vertical back porch (lines)
//   SYNC_POL   0    active level of hsync/vsync (0 = active-low)
// PORTS
//   clk_25       in   1   pixel clock; all state on rising edge
//   reset_n      in   1   asynchronous, active-low reset
//   hsync        out  1   horizontal sync, level per SYNC_POL
//   vsync        out  1   vertical sync, level per SYNC_POL
//   video_on     out  1   1 = pixel_x/pixel_y are inside the visible area
//   pixel_x      out  10  horizontal position, 0..H_TOTAL-1
//   pixel_y      out  10  vertical position, 0..V_TOTAL-1
//   frame_start  out  1   one-cycle strobe at pixel (0,0)
// BEHAVIOUR
//   - H_TOTAL = sum of H_* (800); V_TOTAL = sum of V_* (525). Both must be <= 1024.
//   - Internal h_cnt/v_cnt: 10-bit counters, both reset to 0.
//   - Per clock: h_cnt increments. At h_cnt = H_TOTAL-1, h_cnt wraps to 0 and
//     v_cnt increments. When both counters are at their maximum
//     (h_cnt = H_TOTAL-1, v_cnt = V_TOTAL-1), both wrap to 0 on the same edge.
//   - Horizontal phase FSM follows h_cnt with this sequence:
//     ACTIVE [0, H_ACTIVE) -> FRONT -> SYNC -> BACK -> ACTIVE.
//     Defaults: SYNC = 656..751.
//   - Vertical phase FSM uses the same sequence on v_cnt and advances only on
//     the h wrap. Defaults: SYNC = lines 490..491.
//   - Every output is registered. On each edge it loads the decode of the
//     current h_cnt/v_cnt, so outputs lag the internal counters by exactly
//     1 cycle. All outputs are mutually aligned with pixel_x/pixel_y.
//   - hsync = SYNC_POL while H is in SYNC, else ~SYNC_POL. vsync is the same,
//     using the V phase.
//   - video_on = (H in ACTIVE) && (V in ACTIVE).
//   - frame_start = 1 only in the cycle where pixel_x = 0 and pixel_y = 0.
//   - Reset values (asserted asynchronously, held while reset_n = 0):
//     h_cnt = 0, v_cnt = 0, pixel_x = 0, pixel_y = 0, video_on = 0,
//     frame_start = 0, hsync = ~SYNC_POL, vsync = ~SYNC_POL.
//   - First edge after reset release: outputs show (0,0) with video_on = 1
//     and frame_start = 1. The internal counter is then at 1.
//   - Reset asserted mid-frame aborts the raster immediately; there is no
//     partial-line completion. Timing restarts from (0,0) on release.
//   - Counters never exceed H_TOTAL-1 / V_TOTAL-1. No illegal FSM state is
//     reachable; any decoded-illegal state returns to ACTIVE with count 0.
// TESTING
//   1. Hold reset_n = 0 for 10 cycles -> hsync = 1, vsync = 1, video_on = 0,
//      pixel_x = 0, pixel_y = 0, frame_start = 0.
//   2. Release reset; observe one line -> hsync low exactly while
//      pixel_x = 656..751 (96 cycles); hsync period = 800 cycles.
//   3. Run 2 frames -> vsync low exactly for pixel_y = 490..491 (1600 cycles),
//      falling with pixel_x = 0; vsync period = 420000 cycles.
//   4. Count video_on over one frame -> 307200 cycles high; high iff
//      pixel_x < 640 and pixel_y < 480. Check pixel_x 639 -> 640 drops video_on.
//   5. Wrap checks -> (799, y) is followed by (0, y+1); (799, 524) is followed
//      by (0, 0) with frame_start = 1. frame_start pulses once per
//      420000 cycles, 1 cycle wide.
//   6. Assert reset_n = 0 asynchronously (between edges) at pixel (300, 200)
//      -> all outputs take reset values with no clock edge. After release, the
//      raster restarts at (0,0) with frame_start = 1.

Source files
------------

// File: rtl/vga_sync_gen_if.sv
// Raster timing bundle from the sync generator to the pixel/colour stage.
// All signals are registered by the generator and mutually aligned.
interface vga_sync_gen_if;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       frame_start;

  modport master (output hsync, vsync, video_on, pixel_x, pixel_y, frame_start);
  modport slave  (input  hsync, vsync, video_on, pixel_x, pixel_y, frame_start);
endinterface

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: h/v counters with phase FSMs, registered outputs
// that show the decode of the counters one pixel clock later; no backpressure.
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic           clk_25,
  input  logic           reset_n,
  vga_sync_gen_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_ACT_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0] H_FP_LAST  = 10'(H_ACTIVE + H_FRONT - 1);
  localparam logic [9:0] H_SY_LAST  = 10'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_ACT_LAST = 10'(V_ACTIVE - 1);
  localparam logic [9:0] V_FP_LAST  = 10'(V_ACTIVE + V_FRONT - 1);
  localparam logic [9:0] V_SY_LAST  = 10'(V_ACTIVE + V_FRONT + V_SYNC - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_t;

  phase_t     h_state, h_state_nxt;
  phase_t     v_state, v_state_nxt;
  logic [9:0] h_cnt, h_cnt_nxt;
  logic [9:0] v_cnt, v_cnt_nxt;
  logic       h_wrap, v_wrap;

  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt   <= '0;
      v_cnt   <= '0;
      h_state <= PH_ACTIVE;
      v_state <= PH_ACTIVE;
    end else begin
      h_cnt   <= h_cnt_nxt;
      v_cnt   <= v_cnt_nxt;
      h_state <= h_state_nxt;
      v_state <= v_state_nxt;
    end
  end

  // Wrap on >= so an out-of-range count can never run away.
  always_comb begin
    h_wrap    = (h_cnt >= H_LAST);
    v_wrap    = (v_cnt >= V_LAST);
    h_cnt_nxt = h_wrap ? 10'd0 : h_cnt + 10'd1;
    v_cnt_nxt = v_cnt;
    if (h_wrap) begin
      v_cnt_nxt = v_wrap ? 10'd0 : v_cnt + 10'd1;
    end
  end

  always_comb begin
    h_state_nxt = h_state;
    case (h_state)
      PH_ACTIVE: if (h_cnt == H_ACT_LAST) h_state_nxt = PH_FRONT;
      PH_FRONT:  if (h_cnt == H_FP_LAST)  h_state_nxt = PH_SYNC;
      PH_SYNC:   if (h_cnt == H_SY_LAST)  h_state_nxt = PH_BACK;
      PH_BACK:   if (h_wrap)              h_state_nxt = PH_ACTIVE;
      default:                            h_state_nxt = PH_ACTIVE;
    endcase
    // Counter wrap always lands on ACTIVE, keeping phase and count in step.
    if (h_wrap) h_state_nxt = PH_ACTIVE;
  end

  always_comb begin
    v_state_nxt = v_state;
    if (h_wrap) begin
      case (v_state)
        PH_ACTIVE: if (v_cnt == V_ACT_LAST) v_state_nxt = PH_FRONT;
        PH_FRONT:  if (v_cnt == V_FP_LAST)  v_state_nxt = PH_SYNC;
        PH_SYNC:   if (v_cnt == V_SY_LAST)  v_state_nxt = PH_BACK;
        PH_BACK:   if (v_wrap)              v_state_nxt = PH_ACTIVE;
        default:                            v_state_nxt = PH_ACTIVE;
      endcase
      if (v_wrap) v_state_nxt = PH_ACTIVE;
    end
  end

  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      vga.hsync       <= ~SYNC_POL;
      vga.vsync       <= ~SYNC_POL;
      vga.video_on    <= 1'b0;
      vga.pixel_x     <= '0;
      vga.pixel_y     <= '0;
      vga.frame_start <= 1'b0;
    end else begin
      vga.hsync       <= (h_state == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
      vga.vsync       <= (v_state == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
      vga.video_on    <= (h_state == PH_ACTIVE) && (v_state == PH_ACTIVE);
      vga.pixel_x     <= h_cnt;
      vga.pixel_y     <= v_cnt;
      vga.frame_start <= (h_cnt == 10'd0) && (v_cnt == 10'd0);
    end
  end

endmodule
